// File: rtl/booth_mult_sequencer.sv
// Radix-2 Booth sequential signed multiplier controller. Drives a shared external
// W-bit adder (A, B, carry-in) and shifts its sum into the HI/LO product pair.
module booth_mult_sequencer #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ctrl_MULT,
  input  logic [W-1:0] data_operandA,
  input  logic [W-1:0] data_operandB,
  output logic [W-1:0] adder_a,
  output logic [W-1:0] adder_b,
  output logic         adder_cin,
  input  logic [W-1:0] adder_sum,
  output logic [W-1:0] data_result,
  output logic         data_exception,
  output logic         data_resultRDY,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic           exc_q, exc_d;
  logic           ovf;
  logic           sumSign;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ctrl_MULT) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adder_a        = '0;
    adder_b        = '0;
    adder_cin      = 1'b0;
    data_resultRDY = 1'b0;
    busy           = 1'b0;
    case (state_q)
      RUN: begin
        busy    = 1'b1;
        adder_a = hi_q;
        case ({lo_q[0], qm1_q})
          2'b01:   adder_b = m_q;
          2'b10: begin
            adder_b   = ~m_q;
            adder_cin = 1'b1;
          end
          default: adder_b = '0;
        endcase
      end
      DONE: begin
        busy           = 1'b1;
        data_resultRDY = 1'b1;
      end
      default: ;
    endcase
  end

  // Recover the (W+1)th bit of HI+addend so the arithmetic shift keeps the true sign.
  assign ovf     = (adder_a[W-1] == adder_b[W-1]) & (adder_sum[W-1] != adder_a[W-1]);
  assign sumSign = adder_sum[W-1] ^ ovf;

  always_comb begin
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE: begin
        if (ctrl_MULT) begin
          m_d   = data_operandA;
          hi_d  = '0;
          lo_d  = data_operandB;
          qm1_d = 1'b0;
          cnt_d = '0;
        end
      end
      RUN: begin
        hi_d  = {sumSign, adder_sum[W-1:1]};
        lo_d  = {adder_sum[0], lo_q[W-1:1]};
        qm1_d = lo_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = lo_d;
          exc_d    = (hi_d != {W{lo_d[W-1]}});
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Self-checking bench for booth_mult_sequencer (W=32) with a behavioural 32-bit adder
// on the shared adder ports and a queue scoreboard of expected products.
module tb_booth_mult_sequencer;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         exc;
  } exp_t;

  localparam logic [W-1:0] VA [5] = '{32'hFFFFFFF9, 32'h7FFFFFFF, 32'h00010000, 32'h80000000, 32'h80000000};
  localparam logic [W-1:0] VB [5] = '{32'h00000006, 32'h00000002, 32'h00010000, 32'h00000001, 32'hFFFFFFFF};
  localparam logic [W-1:0] VR [5] = '{32'hFFFFFFD6, 32'hFFFFFFFE, 32'h00000000, 32'h80000000, 32'h80000000};
  localparam logic         VE [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  logic         clock = 1'b0;
  logic         reset;
  logic         ctrlMult;
  logic [W-1:0] opA, opB;
  logic [W-1:0] adderA, adderB, adderSum;
  logic         adderCin;
  logic [W-1:0] result;
  logic         exc, rdy, busy;

  exp_t expQ[$];
  exp_t monEntry;
  int   compared   = 0;
  int   mismatched = 0;
  int   rdyCount   = 0;

  always #5 clock = ~clock;

  assign adderSum = adderA + adderB + {{(W-1){1'b0}}, adderCin};

  booth_mult_sequencer #(.W(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrlMult),
    .data_operandA  (opA),
    .data_operandB  (opB),
    .adder_a        (adderA),
    .adder_b        (adderB),
    .adder_cin      (adderCin),
    .adder_sum      (adderSum),
    .data_result    (result),
    .data_exception (exc),
    .data_resultRDY (rdy),
    .busy           (busy)
  );

  // Every ready pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && rdy) begin
      rdyCount++;
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpectedRdy: got pulse with result=%h, required no pulse", result);
      end else begin
        monEntry = expQ.pop_front();
        if (result !== monEntry.res) begin
          mismatched++;
          $display("[TB] FAIL result: got %h, required %h", result, monEntry.res);
        end
        compared++;
        if (exc !== monEntry.exc) begin
          mismatched++;
          $display("[TB] FAIL exception: got %b, required %b (result %h)", exc, monEntry.exc, monEntry.res);
        end
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, p;
    exp_t e;
    sa    = {{32{a[31]}}, a};
    sb    = {{32{b[31]}}, b};
    p     = sa * sb;
    e.res = p[31:0];
    e.exc = (p[63:32] != {32{p[31]}});
    return e;
  endfunction

  // Issue a one-cycle start; returns at the first negedge after the start edge.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] er, input logic ee);
    exp_t e;
    @(negedge clock);
    opA      = a;
    opB      = b;
    ctrlMult = 1'b1;
    e.res    = er;
    e.exc    = ee;
    expQ.push_back(e);
    @(negedge clock);
    ctrlMult = 1'b0;
  endtask

  task automatic waitDrain(output int lat);
    lat = 1;
    while (expQ.size() != 0 && lat < 100) begin
      @(negedge clock);
      #1;
      lat++;
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drainTimeout: got %0d pending results, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ctrlMult = 1'b1;
    opA      = 32'd9;
    opB      = 32'd9;
    repeat (2) @(negedge clock);
    reset    = 1'b0;
    ctrlMult = 1'b0;
    compared++;
    if ({result, exc, rdy, busy} !== '0) begin
      mismatched++;
      $display("[TB] FAIL resetOutputs: got result=%h exc=%b rdy=%b busy=%b, required all 0", result, exc, rdy, busy);
    end
    compared++;
    if ({adderA, adderB, adderCin} !== '0) begin
      mismatched++;
      $display("[TB] FAIL resetAdder: got a=%h b=%h cin=%b, required all 0", adderA, adderB, adderCin);
    end
    @(negedge clock);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL resetBeatsStart: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic();
    int busyCnt;
    int rdyAt;
    applyStimulus(32'd3, 32'd5, 32'h0000000F, 1'b0);
    compared++;
    if ({adderA, adderB, adderCin} !== {32'h0, 32'hFFFFFFFC, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL firstSub: got a=%h b=%h cin=%b, required 00000000 fffffffc 1", adderA, adderB, adderCin);
    end
    busyCnt = busy ? 1 : 0;
    rdyAt   = rdy ? 1 : 0;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clock);
      if (busy) busyCnt++;
      if (rdy && rdyAt == 0) rdyAt = n;
    end
    compared++;
    if (rdyAt != 33) begin
      mismatched++;
      $display("[TB] FAIL latency: got rdy at +%0d, required +33", rdyAt);
    end
    compared++;
    if (busyCnt != 33) begin
      mismatched++;
      $display("[TB] FAIL busyCycles: got %0d, required 33", busyCnt);
    end
    compared++;
    if (result !== 32'h0000000F || rdy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL resultHold: got result=%h rdy=%b, required 0000000f 0", result, rdy);
    end
    compared++;
    if ({adderA, adderB, adderCin} !== '0) begin
      mismatched++;
      $display("[TB] FAIL idleAdder: got a=%h b=%h cin=%b, required all 0", adderA, adderB, adderCin);
    end
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL basicDrain: got %0d pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_vectors();
    int lat;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(VA[i], VB[i], VR[i], VE[i]);
      waitDrain(lat);
      @(negedge clock);
    end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    applyStimulus(32'd100, 32'hFFFFFFFD, 32'hFFFFFED4, 1'b0);
    repeat (4) @(negedge clock);
    opA      = 32'h0BADF00D;
    opB      = 32'h12345678;
    ctrlMult = 1'b1;
    repeat (4) @(negedge clock);
    ctrlMult = 1'b0;
    waitDrain(lat);
    repeat (2) @(negedge clock);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL startNotQueued: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    int seenBefore;
    exp_t e;
    e = model(32'h00012345, 32'h00000777);
    applyStimulus(32'h00012345, 32'h00000777, e.res, e.exc);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    expQ.delete();
    compared++;
    if ({result, exc, rdy, busy} !== '0) begin
      mismatched++;
      $display("[TB] FAIL midReset: got result=%h exc=%b rdy=%b busy=%b, required all 0", result, exc, rdy, busy);
    end
    seenBefore = rdyCount;
    repeat (45) @(negedge clock);
    compared++;
    if (rdyCount != seenBefore) begin
      mismatched++;
      $display("[TB] FAIL abortedRdy: got %0d pulses after reset, required 0", rdyCount - seenBefore);
    end
    applyStimulus(32'd2, 32'd3, 32'd6, 1'b0);
    waitDrain(lat);
    compared++;
    if (lat != 33) begin
      mismatched++;
      $display("[TB] FAIL restartLatency: got +%0d, required +33", lat);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    exp_t e;
    first  = 0;
    second = 0;
    @(negedge clock);
    opA      = 32'd4;
    opB      = 32'd5;
    ctrlMult = 1'b1;
    e.res = 32'd20;
    e.exc = 1'b0;
    expQ.push_back(e);
    @(negedge clock);
    opA   = 32'd7;
    opB   = 32'hFFFFFFFD;
    e.res = 32'hFFFFFFEB;
    e.exc = 1'b0;
    expQ.push_back(e);
    for (int n = 2; n <= 75; n++) begin
      @(negedge clock);
      if (n == 35) ctrlMult = 1'b0;
      if (rdy) begin
        if (first == 0) first = n;
        else if (second == 0) second = n;
      end
    end
    compared++;
    if (first != 33 || second - first != 34) begin
      mismatched++;
      $display("[TB] FAIL heldStart: got rdy at +%0d and +%0d, required +33 and +67", first, second);
    end
    compared++;
    if (expQ.size() != 0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL heldDrain: got %0d pending busy=%b, required 0 pending busy=0", expQ.size(), busy);
      expQ.delete();
    end
  endtask

  task automatic test_random();
    int lat;
    exp_t e;
    logic [W-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom();
      b = (i % 2 == 0) ? W'($urandom_range(0, 65535)) : W'($urandom());
      e = model(a, b);
      applyStimulus(a, b, e.res, e.exc);
      waitDrain(lat);
      @(negedge clock);
    end
  endtask

  initial begin
    reset    = 1'b1;
    ctrlMult = 1'b0;
    opA      = '0;
    opB      = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_inputs();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
